// File: rtl/control_32_pkg.sv
// rtl/control_32_pkg.sv - opcode/funct constants and control field encodings for control_32
package control_32_pkg;

  localparam logic [5:0] OPC_R_TYPE  = 6'b000000;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] FUNCT_JR    = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    TOREG_ALU = 2'b00,
    TOREG_MEM = 2'b01,
    TOREG_PC4 = 2'b10
  } mem_toreg_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_R31  = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_TARGET = 2'b01,
    JMP_REG    = 2'b10
  } jump_e;

endpackage

// File: rtl/control_32_err_log.sv
// rtl/control_32_err_log.sv - sticky illegal-opcode flag and saturating 8-bit error counter
module control_32_err_log (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       err_i,
  output logic       err_sticky_o,
  output logic [7:0] err_count_o
);

  logic       sticky_q, sticky_d;
  logic [7:0] count_q, count_d;

  always_comb begin
    sticky_d = sticky_q | err_i;
    count_d  = count_q;
    // Counter holds at all-ones rather than wrapping back to zero.
    if (err_i && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign err_sticky_o = sticky_q;
  assign err_count_o  = count_q;

endmodule

// File: rtl/control_32.sv
// rtl/control_32.sv - combinational main decoder for a 32-bit MIPS-like datapath
// Optional error logging enabled by defining CONTROL_32_ERR_LOG_EN.
module control_32
  import control_32_pkg::*;
#(
  parameter logic [5:0] r_type  = OPC_R_TYPE,
  parameter logic [5:0] lw      = OPC_LW,
  parameter logic [5:0] sw      = OPC_SW,
  parameter logic [5:0] beq     = OPC_BEQ,
  parameter logic [5:0] bne     = OPC_BNE,
  parameter logic [5:0] addi    = OPC_ADDI,
  parameter logic [5:0] j       = OPC_J,
  parameter logic [5:0] jal     = OPC_JAL,
  parameter logic [5:0] jr_func = FUNCT_JR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [1:0] alu_op,
  output logic [1:0] mem_toreg,
  output logic       mem_write,
  output logic       mem_read,
  output logic [1:0] branch,
  output logic       alu_src,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic [1:0] jump,
  output logic       err_illegal_opcode,
  output logic       err_sticky,
  output logic [7:0] err_count
);

  always_comb begin
    alu_op             = ALU_ADD;
    mem_toreg          = TOREG_ALU;
    mem_write          = 1'b0;
    mem_read           = 1'b0;
    branch             = BR_NONE;
    alu_src            = 1'b0;
    reg_dst            = DST_RT;
    reg_write          = 1'b0;
    jump               = JMP_NONE;
    err_illegal_opcode = 1'b0;
    case (opcode)
      r_type: begin
        if (funct == jr_func) begin
          jump = JMP_REG;
        end else begin
          alu_op    = ALU_FUNCT;
          reg_dst   = DST_RD;
          reg_write = 1'b1;
        end
      end
      lw: begin
        mem_toreg = TOREG_MEM;
        mem_read  = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      sw: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      beq: begin
        alu_op = ALU_SUB;
        branch = BR_EQ;
      end
      bne: begin
        alu_op = ALU_SUB;
        branch = BR_NE;
      end
      addi: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      j: begin
        jump = JMP_TARGET;
      end
      jal: begin
        jump      = JMP_TARGET;
        reg_dst   = DST_R31;
        mem_toreg = TOREG_PC4;
        reg_write = 1'b1;
      end
      default: begin
        err_illegal_opcode = 1'b1;
      end
    endcase
  end

`ifdef CONTROL_32_ERR_LOG_EN
  control_32_err_log u_err_log (
    .clk          (clk),
    .rst_n        (rst_n),
    .err_i        (err_illegal_opcode),
    .err_sticky_o (err_sticky),
    .err_count_o  (err_count)
  );
`else
  // Clock and reset have no loads when logging is compiled out.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign err_sticky     = 1'b0;
  assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_control_32.sv
// tb/tb_control_32.sv - table-driven decode checks plus error-log sequences for control_32
module tb_control_32;

`ifdef CONTROL_32_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [1:0] alu_op;
  logic [1:0] mem_toreg;
  logic       mem_write;
  logic       mem_read;
  logic [1:0] branch;
  logic       alu_src;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic [1:0] jump;
  logic       err_illegal_opcode;
  logic       err_sticky;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  control_32 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .opcode             (opcode),
    .funct              (funct),
    .alu_op             (alu_op),
    .mem_toreg          (mem_toreg),
    .mem_write          (mem_write),
    .mem_read           (mem_read),
    .branch             (branch),
    .alu_src            (alu_src),
    .reg_dst            (reg_dst),
    .reg_write          (reg_write),
    .jump               (jump),
    .err_illegal_opcode (err_illegal_opcode),
    .err_sticky         (err_sticky),
    .err_count          (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {alu_op, mem_toreg, mem_write, mem_read, branch, alu_src, reg_dst, reg_write, jump, err}
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [14:0] exp;
  } vec_t;

  localparam logic [14:0] E_RTYPE = 15'b10_00_0_0_00_0_01_1_00_0;
  localparam logic [14:0] E_JR    = 15'b00_00_0_0_00_0_00_0_10_0;
  localparam logic [14:0] E_LW    = 15'b00_01_0_1_00_1_00_1_00_0;
  localparam logic [14:0] E_SW    = 15'b00_00_1_0_00_1_00_0_00_0;
  localparam logic [14:0] E_BEQ   = 15'b01_00_0_0_01_0_00_0_00_0;
  localparam logic [14:0] E_BNE   = 15'b01_00_0_0_10_0_00_0_00_0;
  localparam logic [14:0] E_ADDI  = 15'b00_00_0_0_00_1_00_1_00_0;
  localparam logic [14:0] E_J     = 15'b00_00_0_0_00_0_00_0_01_0;
  localparam logic [14:0] E_JAL   = 15'b00_10_0_0_00_0_10_1_01_0;
  localparam logic [14:0] E_ILL   = 15'b00_00_0_0_00_0_00_0_00_1;

  vec_t vecs [18];

  function automatic logic [14:0] decode_bus();
    return {alu_op, mem_toreg, mem_write, mem_read, branch, alu_src,
            reg_dst, reg_write, jump, err_illegal_opcode};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{"r_add",     6'b000000, 6'b100000, E_RTYPE};
    vecs[1]  = '{"r_sub",     6'b000000, 6'b100010, E_RTYPE};
    vecs[2]  = '{"jr",        6'b000000, 6'b001000, E_JR};
    vecs[3]  = '{"lw",        6'b100011, 6'b000000, E_LW};
    vecs[4]  = '{"lw_fn_jr",  6'b100011, 6'b001000, E_LW};
    vecs[5]  = '{"sw",        6'b101011, 6'b111111, E_SW};
    vecs[6]  = '{"beq",       6'b000100, 6'b010101, E_BEQ};
    vecs[7]  = '{"bne",       6'b000101, 6'b000000, E_BNE};
    vecs[8]  = '{"addi",      6'b001000, 6'b001000, E_ADDI};
    vecs[9]  = '{"j",         6'b000010, 6'b100000, E_J};
    vecs[10] = '{"jal",       6'b000011, 6'b001000, E_JAL};
    vecs[11] = '{"ill_0e",    6'b001110, 6'b000000, E_ILL};
    vecs[12] = '{"ill_3f",    6'b111111, 6'b001000, E_ILL};
    vecs[13] = '{"ill_3b",    6'b111011, 6'b100000, E_ILL};
    vecs[14] = '{"ill_1e",    6'b011110, 6'b000000, E_ILL};
    vecs[15] = '{"ill_3a",    6'b111010, 6'b000000, E_ILL};
    vecs[16] = '{"ill_27",    6'b100111, 6'b000000, E_ILL};
    vecs[17] = '{"ill_01",    6'b000001, 6'b000000, E_ILL};

    rst_n  = 1'b0;
    opcode = 6'b100011;
    funct  = 6'b000000;
    #1;
    check("decode_in_reset", {17'd0, decode_bus()}, {17'd0, E_LW});
    repeat (2) @(negedge clk);
    check("rst_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_count",  {24'd0, err_count},  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      opcode = vecs[i].op;
      funct  = vecs[i].fn;
      #1;
      check(vecs[i].name, {17'd0, decode_bus()}, {17'd0, vecs[i].exp});
    end

    // Clear log state left by the illegal vectors above.
    @(negedge clk);
    opcode = 6'b000000;
    funct  = 6'b100000;
    rst_n  = 1'b0;
    #1;
    check("clr_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    check("idle_sticky", {31'd0, err_sticky}, 32'd0);
    opcode = 6'b111111;
    repeat (3) @(negedge clk);
    check("three_sticky", {31'd0, err_sticky}, {31'd0, LOG_EN});
    check("three_count",  {24'd0, err_count},  LOG_EN ? 32'd3 : 32'd0);

    opcode = 6'b100011;
    repeat (2) @(negedge clk);
    check("hold_sticky", {31'd0, err_sticky}, {31'd0, LOG_EN});
    check("hold_count",  {24'd0, err_count},  LOG_EN ? 32'd3 : 32'd0);

    opcode = 6'b111010;
    repeat (251) @(negedge clk);
    check("count_254", {24'd0, err_count}, LOG_EN ? 32'd254 : 32'd0);
    @(negedge clk);
    check("count_255", {24'd0, err_count}, LOG_EN ? 32'd255 : 32'd0);
    repeat (48) @(negedge clk);
    check("count_sat", {24'd0, err_count}, LOG_EN ? 32'd255 : 32'd0);

    #2;
    rst_n = 1'b0;
    #1;
    check("async_sticky", {31'd0, err_sticky}, 32'd0);
    check("async_count",  {24'd0, err_count},  32'd0);
    check("async_decode", {17'd0, decode_bus()}, {17'd0, E_ILL});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rel_count", {24'd0, err_count}, LOG_EN ? 32'd1 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
